// File: rtl/word_scroll_ctrl.sv
// Scrolling-window row sequencer for a 32 x 128 glyph ROM feeding serial LED column drivers.
// Latency: one row = 1 fetch + 2*WIN_W shift + 1 latch + ROW_HOLD display cycles; all outputs are flops.
// Backpressure: none; en is honoured only at row boundaries and pause only freezes the scroll divider.
module word_scroll_ctrl #(
    parameter int WIN_W      = 32,
    parameter int ROW_HOLD   = 1000,
    parameter int SCROLL_DIV = 5000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pause,
    input  logic         dir,
    output logic [4:0]   rom_addr,
    input  logic [127:0] M,
    output logic         sdo,
    output logic         sclk,
    output logic         latch,
    output logic [4:0]   row_sel,
    output logic         oe_n,
    output logic [6:0]   offset,
    output logic         frame_done
);

    // Counter widths; a 1-cycle hold or a divide-by-1 still needs a 1-bit counter.
    localparam int HOLD_W = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
    localparam int DIV_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [6:0]        K_LAST    = 7'(WIN_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
    localparam logic [4:0]        LAST_ROW  = 5'd31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Internal sequencing state.
    logic [127:0]      row_q, row_d;      // captured ROM row for the row being shifted
    logic [6:0]        k_q, k_d;          // window column index, 0 = leftmost
    logic              ph_q, ph_d;        // shift phase: 0 = data setup, 1 = sclk high
    logic [HOLD_W-1:0] hold_q, hold_d;    // display cycles elapsed in HOLD
    logic [DIV_W-1:0]  div_q, div_d;      // scroll divider
    logic              pending_q, pending_d;

    // Next values of the registered outputs.
    logic [4:0] rom_addr_d;
    logic       sdo_d;
    logic       sclk_d;
    logic       latch_d;
    logic [4:0] row_sel_d;
    logic       oe_n_d;
    logic [6:0] offset_d;
    logic       frame_done_d;

    // Helpers for the combinational block.
    logic       tick;
    logic       boundary;
    logic [6:0] col;

    // Next-state, divider, pending flag and next output values.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        k_d          = k_q;
        ph_d         = ph_q;
        hold_d       = hold_q;
        div_d        = div_q;
        pending_d    = pending_q;
        rom_addr_d   = rom_addr;
        row_sel_d    = row_sel;
        offset_d     = offset;
        frame_done_d = 1'b0;
        tick         = 1'b0;
        boundary     = 1'b0;
        sdo_d        = sdo;
        sclk_d       = 1'b0;
        latch_d      = 1'b0;
        oe_n_d       = 1'b1;
        col          = '0;

        // Scroll divider runs only while enabled and not paused.
        if (en && !pause) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = FETCH;
                    rom_addr_d = '0;
                end
            end

            FETCH: begin
                // ROM data is combinational from the registered rom_addr.
                row_d   = M;
                k_d     = '0;
                ph_d    = 1'b0;
                state_d = SHIFT;
            end

            SHIFT: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else if (k_q == K_LAST) begin
                    ph_d      = 1'b0;
                    state_d   = LATCH;
                    // row_sel changes together with the latch strobe.
                    row_sel_d = rom_addr;
                end else begin
                    k_d  = k_q + 7'd1;
                    ph_d = 1'b0;
                end
            end

            LATCH: begin
                hold_d  = '0;
                state_d = HOLD;
            end

            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    if (rom_addr == LAST_ROW) begin
                        // Frame boundary: the only place the offset may move.
                        boundary     = 1'b1;
                        frame_done_d = 1'b1;
                        rom_addr_d   = '0;
                        if (pending_q) begin
                            offset_d = dir ? (offset - 7'd1) : (offset + 7'd1);
                        end
                        state_d = en ? FETCH : IDLE;
                    end else if (en) begin
                        rom_addr_d = rom_addr + 5'd1;
                        state_d    = FETCH;
                    end else begin
                        rom_addr_d = '0;
                        state_d    = IDLE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                rom_addr_d = '0;
            end
        endcase

        // Consume the pending step at the boundary; a tick in the same cycle
        // re-arms it so that tick is applied at the following boundary.
        if (boundary && pending_q) begin
            pending_d = 1'b0;
        end
        if (tick) begin
            pending_d = 1'b1;
        end

        // Outputs reflect the state being entered so they line up with it.
        sclk_d  = (state_d == SHIFT) && ph_d;
        latch_d = (state_d == LATCH);
        oe_n_d  = (state_d != HOLD);
        if ((state_d == SHIFT) && !ph_d) begin
            // 7-bit sum wraps the window around column 127 -> 0.
            col   = offset + k_d;
            sdo_d = row_d[col];
        end
    end

    // State, sequencing counters and all output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            k_q        <= '0;
            ph_q       <= 1'b0;
            hold_q     <= '0;
            div_q      <= '0;
            pending_q  <= 1'b0;
            rom_addr   <= '0;
            sdo        <= 1'b0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            row_sel    <= '0;
            oe_n       <= 1'b1;
            offset     <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            k_q        <= k_d;
            ph_q       <= ph_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            pending_q  <= pending_d;
            rom_addr   <= rom_addr_d;
            sdo        <= sdo_d;
            sclk       <= sclk_d;
            latch      <= latch_d;
            row_sel    <= row_sel_d;
            oe_n       <= oe_n_d;
            offset     <= offset_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_word_scroll_ctrl.sv
// Bench for word_scroll_ctrl with short row/scroll timing to keep frames small.
// Table of latched-row expectations plus hand sequences for reset, pause and enable drop.
// Outputs sampled 1 time unit after the rising edge; a monitor samples on falling edges.
module tb_word_scroll_ctrl;

    localparam int WIN_W      = 32;
    localparam int ROW_HOLD   = 10;
    localparam int SCROLL_DIV = 10;
    localparam int ROW_P      = 2 + 2 * WIN_W + ROW_HOLD;
    localparam int FRAME_P    = 32 * ROW_P;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         pause = 1'b0;
    logic         dir = 1'b0;
    logic [4:0]   rom_addr;
    logic [127:0] M;
    logic         sdo, sclk, latch, oe_n, frame_done;
    logic [4:0]   row_sel;
    logic [6:0]   offset;

    word_scroll_ctrl #(
        .WIN_W(WIN_W), .ROW_HOLD(ROW_HOLD), .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pause(pause), .dir(dir),
        .rom_addr(rom_addr), .M(M), .sdo(sdo), .sclk(sclk), .latch(latch),
        .row_sel(row_sel), .oe_n(oe_n), .offset(offset), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Glyph ROM: columns 0..31 hold a 32-bit word MSB-first, columns 32..127 are blank.
    function automatic logic [127:0] rom_row(input logic [4:0] a);
        logic [31:0]  w;
        logic [127:0] m;
        case (a)
            5'd2:    w = 32'h00300700;
            5'd3:    w = 32'h1E3C0F80;
            default: w = {8'hC3, 19'h0, a};
        endcase
        m = '0;
        for (int k = 0; k < 32; k++) m[k] = w[31 - k];
        return m;
    endfunction

    always_comb M = rom_row(rom_addr);

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Falling-edge monitor: serial capture, latch log, and timing invariants.
    int          cyc = 0;
    logic        sclk_prev;
    logic [31:0] cap, lat_word;
    int          nbits, lat_bits, lat_row, lat_off, lat_frame, lat_seen, frames;
    bit          mon_on = 1'b0;
    logic [4:0]  addr_prev;
    logic        fd_prev;
    bit          addr_have, fd_have;
    int          addr_last, addr_bad, addr_chg;
    int          fd_last, fd_bad, fd_cnt;
    int          oe_run, oe_bad, oe_runs;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sclk_prev = 1'b0; cap = '0; nbits = 0; lat_word = '0; lat_bits = 0;
            lat_row = -1; lat_off = -1; lat_frame = -1; lat_seen = 0; frames = 0;
            addr_prev = '0; fd_prev = 1'b0; addr_have = 1'b0; fd_have = 1'b0;
            addr_last = 0; addr_bad = 0; addr_chg = 0; fd_last = 0; fd_bad = 0; fd_cnt = 0;
            oe_run = 0; oe_bad = 0; oe_runs = 0;
        end else begin
            if (sclk && !sclk_prev) begin
                cap = {cap[30:0], sdo};
                nbits++;
            end
            sclk_prev = sclk;
            if (latch) begin
                lat_word = cap; lat_bits = nbits; lat_row = int'(row_sel);
                lat_off = int'(offset); lat_frame = frames; lat_seen++; nbits = 0;
            end
            if (frame_done) frames++;
            if (mon_on) begin
                if (rom_addr != addr_prev) begin
                    addr_chg++;
                    if (rom_addr != addr_prev + 5'd1) addr_bad++;
                    if (addr_have && (cyc - addr_last != ROW_P)) addr_bad++;
                    addr_have = 1'b1; addr_last = cyc;
                end
                if (frame_done) begin
                    if (fd_prev) fd_bad++;
                    else begin
                        fd_cnt++;
                        if (fd_have && (cyc - fd_last != FRAME_P)) fd_bad++;
                        fd_have = 1'b1; fd_last = cyc;
                    end
                end
                if (!oe_n) oe_run++;
                else if (oe_run > 0) begin
                    oe_runs++;
                    if (oe_run != ROW_HOLD) oe_bad++;
                    oe_run = 0;
                end
            end
            addr_prev = rom_addr;
            fd_prev = frame_done;
        end
    end

    task automatic wait_latch(input int frame, input int row, output bit ok);
        int seen0;
        seen0 = lat_seen;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME_P && !ok; i++) begin
            @(posedge clk); #1;
            if (lat_seen != seen0) begin
                seen0 = lat_seen;
                if (lat_row == row && (frame < 0 || lat_frame == frame)) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME_P + ROW_P && !ok; i++) begin
            @(posedge clk); #1;
            if (frame_done) ok = 1'b1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_sdo"}, 32'(sdo), 0);
        chk({tag, "_sclk"}, 32'(sclk), 0);
        chk({tag, "_latch"}, 32'(latch), 0);
        chk({tag, "_row_sel"}, 32'(row_sel), 0);
        chk({tag, "_oe_n"}, 32'(oe_n), 1);
        chk({tag, "_offset"}, 32'(offset), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    typedef struct {
        int          frame;
        int          row;
        logic [6:0]  off;
        logic [31:0] word;
        logic        dir_next;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        int held;
        int lowcnt;

        // frame, row, offset shown, expected 32-bit window MSB-first, dir afterwards
        vecs[0] = '{0, 2,  7'd0,   32'h00300700, 1'b1};
        vecs[1] = '{0, 3,  7'd0,   32'h1E3C0F80, 1'b1};
        vecs[2] = '{1, 3,  7'd127, 32'h0F1E07C0, 1'b0};
        vecs[3] = '{2, 0,  7'd0,   32'hC3000000, 1'b0};
        vecs[4] = '{3, 5,  7'd1,   32'h8600000A, 1'b0};
        vecs[5] = '{4, 31, 7'd2,   32'h0C00007C, 1'b0};

        // Reset and idle with en low.
        rst = 1'b1; en = 1'b0; pause = 1'b0; dir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("idle_rom_addr", 32'(rom_addr), 0);
            chk("idle_oe_n", 32'(oe_n), 1);
            chk("idle_sclk", 32'(sclk), 0);
            chk("idle_latch", 32'(latch), 0);
            chk("idle_offset", 32'(offset), 0);
        end

        // Asynchronous reset in the middle of a shift.
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (sclk) ok = 1'b1;
        end
        chk("reach_shift", 32'(ok), 1);
        chk("pre_rst_sdo", 32'(sdo), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midshift_rst");
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Continuous run: dir=1 so the first step wraps 0 -> 127.
        dir = 1'b1;
        en = 1'b1;
        mon_on = 1'b1;
        for (int v = 0; v < 6; v++) begin
            wait_latch(vecs[v].frame, vecs[v].row, ok);
            chk($sformatf("v%0d_latch_seen", v), 32'(ok), 1);
            chk($sformatf("v%0d_row_sel", v), 32'(row_sel), 32'(vecs[v].row));
            chk($sformatf("v%0d_latch_width", v), 32'(latch), 0);
            chk($sformatf("v%0d_offset", v), lat_off, 32'(vecs[v].off));
            chk($sformatf("v%0d_nbits", v), lat_bits, WIN_W);
            chk($sformatf("v%0d_window", v), lat_word, vecs[v].word);
            dir = vecs[v].dir_next;
        end

        // Pause: the step already pending in frame 4 lands, then the offset freezes.
        pause = 1'b1;
        wait_fd(ok);
        chk("pause_fd0_seen", 32'(ok), 1);
        chk("pause_fd0_offset", 32'(offset), 3);
        for (int f = 1; f <= 3; f++) begin
            wait_fd(ok);
            chk($sformatf("pause_fd%0d_seen", f), 32'(ok), 1);
            chk($sformatf("pause_fd%0d_offset", f), 32'(offset), 3);
        end
        pause = 1'b0;
        wait_fd(ok);
        chk("resume_fd_seen", 32'(ok), 1);
        chk("resume_offset", 32'(offset), 4);

        // Timing invariants gathered over the continuous run.
        mon_on = 1'b0;
        chk("addr_step_errors", addr_bad, 0);
        chk("addr_changes_seen", 32'(addr_chg >= 280), 1);
        chk("frame_done_errors", fd_bad, 0);
        chk("frame_done_count", 32'(fd_cnt >= 8), 1);
        chk("oe_run_errors", oe_bad, 0);
        chk("oe_runs_seen", 32'(oe_runs >= 280), 1);

        // Enable drop in the middle of row 5's shift.
        ok = 1'b0;
        for (int i = 0; i < 8 * ROW_P && !ok; i++) begin
            @(posedge clk); #1;
            if (rom_addr == 5'd5) ok = 1'b1;
        end
        chk("reach_row5", 32'(ok), 1);
        repeat (33) @(posedge clk);
        #1;
        chk("midrow_oe_n", 32'(oe_n), 1);
        en = 1'b0;
        wait_latch(-1, 5, ok);
        chk("drop_latch_seen", 32'(ok), 1);
        chk("drop_nbits", lat_bits, WIN_W);
        chk("drop_window", lat_word, 32'h30000050);
        for (int i = 0; i < 4 && oe_n; i++) begin
            @(posedge clk); #1;
        end
        lowcnt = 0;
        while (!oe_n && lowcnt < 4 * ROW_HOLD) begin
            lowcnt++;
            @(posedge clk); #1;
        end
        chk("drop_hold_len", lowcnt, ROW_HOLD);
        for (int i = 0; i < 2 * ROW_P; i++) begin
            chk("stop_rom_addr", 32'(rom_addr), 0);
            chk("stop_oe_n", 32'(oe_n), 1);
            chk("stop_latch", 32'(latch), 0);
            @(posedge clk); #1;
        end
        held = int'(offset);
        chk("stop_offset", held, 4);

        // Restart from row 0 with the offset unchanged.
        en = 1'b1;
        wait_latch(-1, 0, ok);
        chk("restart_latch_seen", 32'(ok), 1);
        chk("restart_offset", lat_off, 4);
        chk("restart_nbits", lat_bits, WIN_W);
        chk("restart_window", lat_word, 32'h30000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
